// File: rtl/half_subtractor_pkg.sv
// Shared definitions for the half subtractor slice:
// the per-lane truth table and the pipeline depth limit.
package half_subtractor_pkg;

    localparam int MAX_LATENCY = 4;

    // Returns {bo, d} for one lane
    function automatic logic [1:0] half_sub_fn(input logic a, input logic b);
        return {~a & b, a ^ b};
    endfunction

endpackage

// File: rtl/half_subtractor_if.sv
// Operand/result bundle for the half subtractor.
// The master drives operands; the slave returns results.
interface half_subtractor_if #(
    parameter int WIDTH = 1
);

    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Bo;
    logic             out_valid;

    modport master (
        output in_valid,
        output A,
        output B,
        input  D,
        input  Bo,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        output D,
        output Bo,
        output out_valid
    );

endinterface

// File: rtl/half_subtractor_cell.sv
// Single-lane combinational half subtractor.
// Shares its truth table with the rest of the codebase.
module half_sub_cell
    import half_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);

    assign {bo, d} = half_sub_fn(a, b);

endmodule

// File: rtl/half_subtractor.sv
// WIDTH independent half subtractor lanes followed by a
// LATENCY-deep free-running result pipeline with valid tracking.
module half_subtractor
    import half_subtractor_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    half_subtractor_if.slave    bus
);

    logic [WIDTH-1:0] d_c;
    logic [WIDTH-1:0] bo_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_sub_cell u_cell (
            .a  (bus.A[i]),
            .b  (bus.B[i]),
            .d  (d_c[i]),
            .bo (bo_c[i])
        );
    end

    if (LATENCY == 0) begin : g_comb
        assign bus.D         = d_c;
        assign bus.Bo        = bo_c;
        assign bus.out_valid = bus.in_valid;
    end else begin : g_pipe
        localparam int DEPTH = (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;

        logic [WIDTH-1:0] d_q  [DEPTH];
        logic [WIDTH-1:0] bo_q [DEPTH];
        logic             v_q  [DEPTH];

        // Data stages shift every cycle; only rst clears them
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    d_q[i]  <= '0;
                    bo_q[i] <= '0;
                    v_q[i]  <= 1'b0;
                end
            end else begin
                d_q[0]  <= d_c;
                bo_q[0] <= bo_c;
                v_q[0]  <= bus.in_valid;
                for (int i = 1; i < DEPTH; i++) begin
                    d_q[i]  <= d_q[i-1];
                    bo_q[i] <= bo_q[i-1];
                    v_q[i]  <= v_q[i-1];
                end
            end
        end

        assign bus.D         = d_q[DEPTH-1];
        assign bus.Bo        = bo_q[DEPTH-1];
        assign bus.out_valid = v_q[DEPTH-1];
    end

endmodule

// File: tb/tb_half_subtractor.sv
// Directed bench for half_subtractor across four
// WIDTH/LATENCY configurations.
module tb_half_subtractor;

    logic clk = 1'b0;
    logic rst1 = 1'b0;
    logic rst2 = 1'b0;
    logic rst3 = 1'b0;
    logic rst4 = 1'b0;

    int checks = 0;
    int errors = 0;

    half_subtractor_if #(.WIDTH(1)) if1 ();
    half_subtractor_if #(.WIDTH(4)) if2 ();
    half_subtractor_if #(.WIDTH(1)) if3 ();
    half_subtractor_if #(.WIDTH(8)) if4 ();

    half_subtractor #(.WIDTH(1), .LATENCY(1)) u1 (.clk(clk), .rst(rst1), .bus(if1));
    half_subtractor #(.WIDTH(4), .LATENCY(2)) u2 (.clk(clk), .rst(rst2), .bus(if2));
    half_subtractor #(.WIDTH(1), .LATENCY(3)) u3 (.clk(clk), .rst(rst3), .bus(if3));
    half_subtractor #(.WIDTH(8), .LATENCY(0)) u4 (.clk(clk), .rst(rst4), .bus(if4));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks {out_valid, D, Bo} of the 1-bit instances as a 3-bit code
    task automatic chk1(input string tag, input logic ov, input logic d, input logic bo,
                        input logic [2:0] exp);
        chk(tag, {5'b0, ov, d, bo}, {5'b0, exp});
    endtask

    logic [7:0] ra;
    logic [7:0] rb;
    logic       rv;

    initial begin
        if1.in_valid = 0; if1.A = '0; if1.B = '0;
        if2.in_valid = 0; if2.A = '0; if2.B = '0;
        if3.in_valid = 0; if3.A = '0; if3.B = '0;
        if4.in_valid = 0; if4.A = '0; if4.B = '0;

        // W1 L1: reset state
        rst1 = 1;
        step();
        chk1("l1_reset", if1.out_valid, if1.D, if1.Bo, 3'b000);
        rst1 = 0;

        // W1 L1: truth table, {ov,D,Bo}
        if1.in_valid = 1; if1.A = 0; if1.B = 0;
        step();
        chk1("tt_00", if1.out_valid, if1.D, if1.Bo, 3'b100);
        if1.A = 0; if1.B = 1;
        step();
        chk1("tt_01", if1.out_valid, if1.D, if1.Bo, 3'b111);
        if1.A = 1; if1.B = 0;
        step();
        chk1("tt_10", if1.out_valid, if1.D, if1.Bo, 3'b110);
        if1.A = 1; if1.B = 1;
        step();
        chk1("tt_11", if1.out_valid, if1.D, if1.Bo, 3'b100);

        // W1 L1: reset held with pending input
        rst1 = 1; if1.A = 0; if1.B = 1;
        step();
        chk1("rst_hold_a", if1.out_valid, if1.D, if1.Bo, 3'b000);
        step();
        chk1("rst_hold_b", if1.out_valid, if1.D, if1.Bo, 3'b000);
        rst1 = 0;
        step();
        chk1("rst_release", if1.out_valid, if1.D, if1.Bo, 3'b111);

        // W1 L1: valid gaps, data still updates
        if1.in_valid = 1; if1.A = 1; if1.B = 0;
        step();
        chk1("gap_v1", if1.out_valid, if1.D, if1.Bo, 3'b110);
        if1.in_valid = 0; if1.A = 0; if1.B = 1;
        step();
        chk1("gap_v0", if1.out_valid, if1.D, if1.Bo, 3'b011);
        if1.in_valid = 1; if1.A = 1; if1.B = 1;
        step();
        chk1("gap_v1b", if1.out_valid, if1.D, if1.Bo, 3'b100);
        if1.in_valid = 0;

        // W4 L2
        rst2 = 1;
        step();
        chk("l2_reset_v", {7'b0, if2.out_valid}, 8'h00);
        rst2 = 0;
        if2.in_valid = 1; if2.A = 4'b0101; if2.B = 4'b0011;
        step();
        chk("l2_mid_v", {7'b0, if2.out_valid}, 8'h00);
        if2.A = 4'b1100; if2.B = 4'b1010;
        step();
        chk("l2_a_v", {7'b0, if2.out_valid}, 8'h01);
        chk("l2_a_d", {4'b0, if2.D}, 8'h06);
        chk("l2_a_bo", {4'b0, if2.Bo}, 8'h02);
        if2.in_valid = 0;
        step();
        chk("l2_b_v", {7'b0, if2.out_valid}, 8'h01);
        chk("l2_b_d", {4'b0, if2.D}, 8'h06);
        chk("l2_b_bo", {4'b0, if2.Bo}, 8'h02);
        step();
        chk("l2_c_v", {7'b0, if2.out_valid}, 8'h00);

        // W1 L3: mid-stream reset flushes in-flight items
        rst3 = 1;
        step();
        rst3 = 0;
        if3.in_valid = 1; if3.A = 0; if3.B = 1;
        step();
        chk1("l3_e1", if3.out_valid, if3.D, if3.Bo, 3'b000);
        rst3 = 1; if3.A = 1; if3.B = 1;
        step();
        chk1("l3_e2", if3.out_valid, if3.D, if3.Bo, 3'b000);
        rst3 = 0; if3.A = 1; if3.B = 0;
        step();
        chk1("l3_flush1", if3.out_valid, if3.D, if3.Bo, 3'b000);
        if3.in_valid = 0; if3.A = 0; if3.B = 0;
        step();
        chk1("l3_flush2", if3.out_valid, if3.D, if3.Bo, 3'b000);
        step();
        chk1("l3_emerge", if3.out_valid, if3.D, if3.Bo, 3'b110);
        step();
        chk1("l3_after", if3.out_valid, if3.D, if3.Bo, 3'b000);

        // W8 L0: every A value, random B, same-cycle results
        for (int i = 0; i < 256; i++) begin
            ra = i[7:0];
            rb = 8'($urandom);
            rv = 1'($urandom);
            if4.A = ra; if4.B = rb; if4.in_valid = rv;
            #1;
            chk("l0_d", if4.D, ra ^ rb);
            chk("l0_bo", if4.Bo, ~ra & rb);
            chk("l0_v", {7'b0, if4.out_valid}, {7'b0, rv});
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
